// File: rtl/uart_rx_ctrl_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding and the
// baud-counter timing constants used by the external counter and by benches.
package uart_rx_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Clocks per bit, and clocks from counter enable to the first mid-bit strobe
    localparam int BPS_PERIOD = 2083;
    localparam int BPS_HALF   = 1041;

endpackage

// File: rtl/rx_sync_edge.sv
// Two-flop synchronizer for the asynchronous rx line, plus falling-edge detect
// on the synchronized value. All flops reset to the idle line level.
module rx_sync_edge (
    input  logic clk,
    input  logic rstn,
    input  logic rx,
    output logic rx_s,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= rx;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rx_s = sync_q;
    // A held-low line (break) never produces a second edge until it returns high
    assign fall = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: frames the synchronized rx line using mid-bit strobes
// from an external baud counter, which it enables through count_sig.
module uart_rx_ctrl
    import uart_rx_ctrl_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 rx,
    input  logic                 bps_clk,
    output logic                 count_sig,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int               CNT_W    = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 count_q, count_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 perr_q, perr_d;
    logic                 par_bad_q, par_bad_d;
    logic                 rx_s;
    logic                 rx_fall;

    rx_sync_edge u_sync (
        .clk  (clk),
        .rstn (rstn),
        .rx   (rx),
        .rx_s (rx_s),
        .fall (rx_fall)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            count_q   <= 1'b0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            perr_q    <= 1'b0;
            par_bad_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            count_q   <= count_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            perr_q    <= perr_d;
            par_bad_q <= par_bad_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        count_d   = count_q;
        par_bad_d = par_bad_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        perr_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Strobes arriving here are stale and deliberately ignored
                if (rx_fall) begin
                    state_d = ST_START;
                    count_d = 1'b1;
                end
            end
            ST_START: begin
                if (bps_clk) begin
                    if (!rx_s) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                        par_bad_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        count_d = 1'b0;
                    end
                end
            end
            ST_DATA: begin
                if (bps_clk) begin
                    shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = PARITY_EN ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (bps_clk) begin
                    par_bad_d = ((^shift_q) ^ rx_s) != PARITY_ODD;
                    state_d   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bps_clk) begin
                    // A bad stop bit outranks a parity error
                    if (rx_s) begin
                        if (PARITY_EN && par_bad_q) begin
                            perr_d = 1'b1;
                        end else begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end
                    end else begin
                        ferr_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                    count_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                count_d = 1'b0;
            end
        endcase
    end

    assign count_sig  = count_q;
    assign rx_data    = data_q;
    assign rx_valid   = valid_q;
    assign frame_err  = ferr_q;
    assign parity_err = perr_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: an 8N1 instance and an 8E1 instance, each fed by its own
// baud-counter model; table vectors, hand-written corner sequences and random frames.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;
    import uart_rx_ctrl_pkg::*;

    typedef struct {
        logic [7:0] d;
        bit         par;
        logic       pbit;
        logic       stopb;
        bit         ev;
        bit         ef;
        bit         ep;
    } vec_t;

    logic       clk   = 1'b0;
    logic       rstn  = 1'b0;
    logic       line  = 1'b1;
    logic       sel_p = 1'b0;
    logic       rx_a, rx_b;
    logic       cs_a, bps_a, valid_a, ferr_a, perr_a, busy_a;
    logic       cs_b, bps_b, valid_b, ferr_b, perr_b, busy_b;
    logic [7:0] data_a, data_b;

    int bit_period = BPS_PERIOD;
    int bit_half   = BPS_HALF;
    int cnt_a = 0;
    int cnt_b = 0;

    int n_cmp = 0;
    int n_bad = 0;
    int nv_a = 0, nf_a = 0, np_a = 0;
    int nv_b = 0, nf_b = 0, np_b = 0;
    int n_multi = 0;
    logic [7:0] got_a[$];
    logic [7:0] exp_a = 8'h00;
    logic [7:0] exp_b = 8'h00;

    always #5 clk = ~clk;

    assign rx_a = sel_p ? 1'b1 : line;
    assign rx_b = sel_p ? line : 1'b1;

    uart_rx_ctrl #(.DATA_BITS(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut_a (
        .clk(clk), .rstn(rstn), .rx(rx_a), .bps_clk(bps_a), .count_sig(cs_a),
        .rx_data(data_a), .rx_valid(valid_a), .frame_err(ferr_a),
        .parity_err(perr_a), .busy(busy_a)
    );

    uart_rx_ctrl #(.DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_b (
        .clk(clk), .rstn(rstn), .rx(rx_b), .bps_clk(bps_b), .count_sig(cs_b),
        .rx_data(data_b), .rx_valid(valid_b), .frame_err(ferr_b),
        .parity_err(perr_b), .busy(busy_b)
    );

    // External baud counters: held at zero while count_sig is low
    always @(posedge clk) begin
        if (!cs_a)                        cnt_a <= 0;
        else if (cnt_a == bit_period - 1) cnt_a <= 0;
        else                              cnt_a <= cnt_a + 1;
        if (!cs_b)                        cnt_b <= 0;
        else if (cnt_b == bit_period - 1) cnt_b <= 0;
        else                              cnt_b <= cnt_b + 1;
    end
    assign bps_a = cs_a && (cnt_a == bit_half);
    assign bps_b = cs_b && (cnt_b == bit_half);

    always @(negedge clk) begin
        if (valid_a) begin
            nv_a <= nv_a + 1;
            got_a.push_back(data_a);
        end
        if (ferr_a)  nf_a <= nf_a + 1;
        if (perr_a)  np_a <= np_a + 1;
        if (valid_b) nv_b <= nv_b + 1;
        if (ferr_b)  nf_b <= nf_b + 1;
        if (perr_b)  np_b <= np_b + 1;
        if ((int'(valid_a) + int'(ferr_a) + int'(perr_a)) > 1 ||
            (int'(valid_b) + int'(ferr_b) + int'(perr_b)) > 1)
            n_multi <= n_multi + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference outcome of one frame, from the line-level rules (even parity on dut_b)
    function automatic void model(input logic [7:0] d, input bit par_en, input logic pbit,
                                  input logic stopb, output bit ev, output bit ef, output bit ep);
        ev = 1'b0;
        ef = 1'b0;
        ep = 1'b0;
        if (!stopb)                                                    ef = 1'b1;
        else if (par_en && ((($countones(d) + int'(pbit)) % 2) != 0)) ep = 1'b1;
        else                                                           ev = 1'b1;
    endfunction

    task automatic send_frame(input logic [7:0] d, input bit use_par, input logic pbit,
                              input logic stopb, input logic after);
        line = 1'b0;
        repeat (bit_period) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            line = d[i];
            repeat (bit_period) @(negedge clk);
        end
        if (use_par) begin
            line = pbit;
            repeat (bit_period) @(negedge clk);
        end
        line = stopb;
        repeat (bit_period) @(negedge clk);
        line = after;
    endtask

    task automatic run_frame(input string name, input logic [7:0] d, input bit par,
                             input logic pbit, input logic stopb,
                             input bit ev, input bit ef, input bit ep);
        int v0, f0, p0;
        sel_p = par;
        v0 = par ? nv_b : nv_a;
        f0 = par ? nf_b : nf_a;
        p0 = par ? np_b : np_a;
        send_frame(d, par, pbit, stopb, 1'b1);
        repeat (10) @(negedge clk);
        if (ev) begin
            if (par) exp_b = d;
            else     exp_a = d;
        end
        check({name, " rx_valid"},   32'((par ? nv_b : nv_a) - v0), 32'(ev));
        check({name, " frame_err"},  32'((par ? nf_b : nf_a) - f0), 32'(ef));
        check({name, " parity_err"}, 32'((par ? np_b : np_a) - p0), 32'(ep));
        check({name, " rx_data"},    32'(par ? data_b : data_a), 32'(par ? exp_b : exp_a));
        check({name, " busy"},       32'(par ? busy_b : busy_a), 32'd0);
        check({name, " count_sig"},  32'(par ? cs_b : cs_a), 32'd0);
        $display("frame %-12s dut=%s data=%02h pbit=%0d stop=%0d expect v/f/p=%0d%0d%0d rx_data=%02h",
                 name, par ? "8E1" : "8N1", d, pbit, stopb, ev, ef, ep, par ? data_b : data_a);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs[8];
        int         v0, f0, p0;
        logic [7:0] d;
        bit         par, ev, ef, ep;
        logic       pbit, stopb;

        vecs[0] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{8'h07, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{8'h07, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{8'h80, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

        // Reset state
        repeat (4) @(negedge clk);
        check("reset count_sig", 32'(cs_a), 32'd0);
        check("reset busy",      32'(busy_a), 32'd0);
        check("reset pulses",    32'({valid_a, ferr_a, perr_a, perr_b}), 32'd0);
        check("reset rx_data",   32'(data_a), 32'd0);
        rstn = 1'b1;
        repeat (10) @(negedge clk);
        check("idle after release", 32'(busy_a | busy_b), 32'd0);

        // Full-rate 8N1 frame
        run_frame("A5_8N1", 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

        // 300-clock glitch: START must abort at the first strobe
        sel_p = 1'b0;
        v0 = nv_a; f0 = nf_a; p0 = np_a;
        line = 1'b0;
        repeat (300) @(negedge clk);
        line = 1'b1;
        check("glitch in START busy", 32'(busy_a), 32'd1);
        repeat (1000) @(negedge clk);
        check("glitch busy",      32'(busy_a), 32'd0);
        check("glitch count_sig", 32'(cs_a), 32'd0);
        check("glitch pulses",    32'((nv_a - v0) + (nf_a - f0) + (np_a - p0)), 32'd0);
        $display("frame glitch300     dut=8N1 aborted busy=%0d", busy_a);

        // Remaining traffic at a shortened bit time (the DUT only sees strobes)
        bit_period = 64;
        bit_half   = 32;

        for (int i = 0; i < 8; i++)
            run_frame($sformatf("vec%0d", i), vecs[i].d, vecs[i].par, vecs[i].pbit,
                      vecs[i].stopb, vecs[i].ev, vecs[i].ef, vecs[i].ep);

        // Back-to-back frames with no idle gap
        sel_p = 1'b0;
        got_a.delete();
        v0 = nv_a;
        send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b1);
        send_frame(8'hAA, 1'b0, 1'b0, 1'b1, 1'b1);
        repeat (10) @(negedge clk);
        exp_a = 8'hAA;
        check("b2b valid count", 32'(nv_a - v0), 32'd2);
        check("b2b first data",  32'(got_a[0]), 32'h55);
        check("b2b second data", 32'(got_a[1]), 32'hAA);
        $display("frame b2b_55_AA     dut=8N1 captured %0d frames", got_a.size());

        // Break: line stays low after a bad stop bit and must not retrigger
        v0 = nv_a; f0 = nf_a;
        send_frame(8'hF0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3 * bit_period) @(negedge clk);
        check("break frame_err", 32'(nf_a - f0), 32'd1);
        check("break no valid",  32'(nv_a - v0), 32'd0);
        check("break busy",      32'(busy_a), 32'd0);
        check("break rx_data",   32'(data_a), 32'(exp_a));
        $display("frame break         dut=8N1 busy=%0d", busy_a);
        line = 1'b1;
        repeat (10) @(negedge clk);
        run_frame("after_break", 8'h6E, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

        // Reset asserted during data bit 4
        sel_p = 1'b0;
        d = 8'h5A;
        v0 = nv_a; f0 = nf_a; p0 = np_a;
        line = 1'b0;
        repeat (bit_period) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            line = d[i];
            repeat (bit_period) @(negedge clk);
        end
        line = d[4];
        repeat (bit_period / 2) @(negedge clk);
        check("pre-reset busy", 32'(busy_a), 32'd1);
        rstn = 1'b0;
        #1;
        check("midreset count_sig", 32'(cs_a), 32'd0);
        check("midreset busy",      32'(busy_a), 32'd0);
        check("midreset pulses",    32'({valid_a, ferr_a, perr_a}), 32'd0);
        check("midreset rx_data",   32'(data_a), 32'd0);
        exp_a = 8'h00;
        exp_b = 8'h00;
        line = 1'b1;
        repeat (5) @(negedge clk);
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        check("midreset no pulse", 32'((nv_a - v0) + (nf_a - f0) + (np_a - p0)), 32'd0);
        $display("frame reset_bit4    dut=8N1 aborted by reset");
        run_frame("rst_recover", 8'h81, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

        // Random frames against the reference model
        for (int k = 0; k < 20; k++) begin
            par   = 1'($urandom_range(1, 0));
            d     = 8'($urandom);
            pbit  = 1'($urandom_range(1, 0));
            stopb = ($urandom_range(3, 0) != 0);
            model(d, par, pbit, stopb, ev, ef, ep);
            run_frame($sformatf("rnd%0d", k), d, par, pbit, stopb, ev, ef, ep);
        end

        check("pulse exclusivity", 32'(n_multi), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
